mio_responder: RTL
==================

# mio_responder

Memory/IO responder on the far end of the multi-cycle CPU's memory handshake. It accepts level-held `MemRead`/`MemWrite` requests with an address and write data. After a parameterised number of wait states it completes the access against an internal word RAM or a small register file, then pulses `MIO_ready` for one cycle with read data valid. It sits between the CPU core and the board I/O as the single bus target.

## Interface
- `RAM_AW`, 10: RAM word-address width; depth is 2^RAM_AW words.
- `WAIT_CYCLES`, 2: extra wait states per access, legal range 0..15.
- `clk`  in  1: the single clock; all state changes on its rising edge.
- `reset_n`  in  1: reset, asynchronous and active-low.
- `MemRead`  in  1: read request, held by the CPU until it sees `MIO_ready`.
- `MemWrite`  in  1: write request, held by the CPU until it sees `MIO_ready`.
- `addr`  in  32: byte address; bits [1:0] are ignored (word access only).
- `wdata`  in  32: write data, valid while `MemWrite` is high.
- `rdata`  out  32: read data; valid in the `MIO_ready` cycle and held until the next completion.
- `MIO_ready`  out  1: one-cycle completion pulse.
- `gpio_out`  out  32: GPIO output register.
- `busy`  out  1: high while an access is in flight (`BUSY` or `ACK`).

## Operation
- Address decode uses `addr[31:28]`:
  - `0x0`: RAM at word index `addr[RAM_AW+1:2]`; upper address bits are ignored, so the RAM aliases.
  - `0xE`: GPIO register. Read/write.
  - `0xF`: free-running 32-bit cycle counter. Read-only; writes are ignored.
  - Any other region: reads return 0 and writes are dropped. The access is still acknowledged, so the CPU never hangs.
- FSM states are `IDLE`, `BUSY`, `ACK`.
- `IDLE`:
  - If `MemWrite` or `MemRead` is high, latch `addr`, `wdata` and the op into internal registers. Load the wait counter with `WAIT_CYCLES`, then go to `BUSY`.
  - If both requests are high, the access is a write.
- `BUSY`:
  - While the counter is nonzero, decrement it.
  - When the counter is 0: commit the write (RAM, GPIO) or capture the read data into `rdata`, set `MIO_ready` to 1, and go to `ACK`.
- `ACK`:
  - `MIO_ready` is high for exactly this cycle.
  - Next state is always `IDLE`. `MIO_ready` returns to 0.
  - The request inputs are ignored in `ACK`; the CPU is still presenting the old request in this cycle.
- Back-to-back accesses: a request present in the cycle after `ACK` is accepted in `IDLE` with no bubble. This covers a write completion followed directly by an instruction fetch.
- Only the latched address and data are used. Changes on the request inputs during `BUSY` have no effect.
- The cycle counter increments every cycle from reset and wraps 0xFFFFFFFF to 0. A read returns the value at the commit edge.
- A GPIO write updates `gpio_out` at the commit edge.

## Timing
- With a request present in cycle T (state `IDLE`), `MIO_ready` is high in cycle T+2+`WAIT_CYCLES`.
  - For `WAIT_CYCLES` = 0, `MIO_ready` is high in cycle T+2.
- Per-access occupancy is `WAIT_CYCLES`+3 cycles, counting the `IDLE` accept cycle.
- Values after reset:
  - state = `IDLE`.
  - `MIO_ready` = 0, `rdata` = 0, `gpio_out` = 0, `busy` = 0.
  - cycle counter = 0, wait counter = 0.
  - RAM contents are not reset.
- Reset asserted mid-access aborts the access. Any write not yet committed at the commit edge is lost, and no `MIO_ready` pulse is produced.

## Structure
- Shared package `mio_pkg` holds:
  - the state encoding (`IDLE`/`BUSY`/`ACK`);
  - the region codes `REG_RAM`=4'h0, `REG_GPIO`=4'hE, `REG_CNT`=4'hF.
- Sub-module `mio_ram`: single-port, synchronous-write word RAM with `RAM_AW` address bits. Its read must be available at the commit edge; an asynchronous read, or a synchronous read presented during `BUSY`, both satisfy this.

## Test plan
- `WAIT_CYCLES`=2: write 0xDEADBEEF to 0x00000010, then read 0x00000010 → `rdata`=0xDEADBEEF, with each `MIO_ready` pulse 1 cycle wide and arriving 4 cycles after the request first appears.
- Write 0x5A to 0xE0000000 → `gpio_out`=0x0000005A at the commit edge. A read of 0xE0000000 returns 0x5A.
- Read 0xF0000000 twice, 10 cycles apart → the returned values differ by exactly 10. A write to 0xF0000000 leaves the counter unperturbed.
- Write completion followed by `MemRead` in the next cycle → the read is accepted without an idle cycle, and its ready arrives `WAIT_CYCLES`+2 cycles later.
- Read 0x30000000 (unmapped) → `rdata`=0 with `MIO_ready` asserted. `MemRead` and `MemWrite` both high to 0x4 → treated as a write.
- Assert `reset_n`=0 while in `BUSY` on a write of 0x1 to 0x8 → no `MIO_ready`, all outputs at reset values. After reset, a write of 0x77 to 0x8 followed by a read returns 0x77.

Source files
------------

// File: rtl/mio_pkg.sv
// Shared definitions for the memory/IO responder: FSM state encoding,
// address region codes and the region decode helper.
package mio_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    ACK  = 2'd2
  } mio_state_e;

  localparam logic [3:0] REG_RAM  = 4'h0;
  localparam logic [3:0] REG_GPIO = 4'hE;
  localparam logic [3:0] REG_CNT  = 4'hF;

  function automatic logic [3:0] region_of(input logic [31:0] byte_addr);
    return byte_addr[31:28];
  endfunction

endpackage

// File: rtl/mio_ram.sv
// Single-port word RAM: synchronous write, asynchronous read so the word is
// already valid when the responder commits a read.
module mio_ram #(
  parameter int RAM_AW = 10
) (
  input  logic              clk,
  input  logic              we,
  input  logic [RAM_AW-1:0] addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata
);

  logic [31:0] mem [2**RAM_AW];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/mio_responder.sv
// Single bus target for the multi-cycle CPU: latches a held request, waits
// WAIT_CYCLES, completes against RAM/GPIO/cycle counter and pulses MIO_ready.
module mio_responder
  import mio_pkg::*;
#(
  parameter int RAM_AW      = 10,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        MIO_ready,
  output logic [31:0] gpio_out,
  output logic        busy
);

  mio_state_e state_q, state_d;
  logic              accept;
  logic              commit;
  logic [3:0]        wait_cnt;
  logic [3:0]        region_q;
  logic [RAM_AW-1:0] word_q;
  logic [31:0]       wdata_q;
  logic              write_q;
  logic [31:0]       cycle_cnt;
  logic [31:0]       ram_rdata;
  logic [31:0]       read_value;
  logic              ram_we;

  // Byte-lane bits and the RAM alias bits are don't-cares for decode.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{addr[27:RAM_AW+2], addr[1:0]};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    commit  = 1'b0;
    case (state_q)
      IDLE: begin
        if (MemRead || MemWrite) begin
          accept  = 1'b1;
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (wait_cnt == 4'd0) begin
          commit  = 1'b1;
          state_d = ACK;
        end
      end
      ACK: begin
        // The CPU still shows the old request here, so it is not sampled.
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      region_q <= 4'h0;
      word_q   <= '0;
      wdata_q  <= 32'h0;
      write_q  <= 1'b0;
      wait_cnt <= 4'd0;
    end else if (accept) begin
      region_q <= region_of(addr);
      word_q   <= addr[RAM_AW+1:2];
      wdata_q  <= wdata;
      write_q  <= MemWrite;
      wait_cnt <= 4'(WAIT_CYCLES);
    end else if (state_q == BUSY && wait_cnt != 4'd0) begin
      wait_cnt <= wait_cnt - 4'd1;
    end
  end

  assign ram_we = commit && write_q && (region_q == REG_RAM);

  mio_ram #(
    .RAM_AW(RAM_AW)
  ) u_ram (
    .clk  (clk),
    .we   (ram_we),
    .addr (word_q),
    .wdata(wdata_q),
    .rdata(ram_rdata)
  );

  always_comb begin
    read_value = 32'h0;
    case (region_q)
      REG_RAM:  read_value = ram_rdata;
      REG_GPIO: read_value = gpio_out;
      REG_CNT:  read_value = cycle_cnt;
      default:  read_value = 32'h0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      MIO_ready <= 1'b0;
      rdata     <= 32'h0;
      gpio_out  <= 32'h0;
    end else begin
      MIO_ready <= commit;
      if (commit && !write_q) begin
        rdata <= read_value;
      end
      if (commit && write_q && region_q == REG_GPIO) begin
        gpio_out <= wdata_q;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cycle_cnt <= 32'h0;
    end else begin
      cycle_cnt <= cycle_cnt + 32'd1;
    end
  end

  assign busy = (state_q != IDLE);

endmodule
